// File: rtl/fetch16_pkg.sv
// fetch16_pkg: definitions shared by the fetch stage, Mux16 and the CPU top.
//   data_width       - datapath and address width of the Hack-style CPU
//   reset_pc_default - PC loaded on reset unless the instance overrides it
//   state_t          - fetch FSM state encoding
package fetch16_pkg;

    localparam int unsigned data_width = 16;
    localparam logic [15:0] reset_pc_default = 16'h0000;

    typedef enum logic {
        st_fetch = 1'b0,
        st_hold  = 1'b1
    } state_t;

endpackage

// File: rtl/fetch16_if.sv
// fetch16_if: signal bundle between the fetch stage and its neighbours.
//   jump/jump_addr                 - redirect request from execute
//   imem_req/imem_addr             - fetch request to instruction memory
//   imem_ack/imem_rdata            - memory response
//   instr/instr_pc/instr_valid     - held instruction towards the consumer
//   instr_taken                    - consumer accepts instr this cycle
// master: the fetch stage; slave: the memory / execute / consumer side.
interface fetch16_if
    import fetch16_pkg::*;
#(
    parameter int unsigned WIDTH = data_width
);
    logic             jump;
    logic [WIDTH-1:0] jump_addr;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;
    logic             instr_valid;
    logic             instr_taken;

    modport master (
        input  jump, jump_addr, imem_ack, imem_rdata, instr_taken,
        output imem_req, imem_addr, instr, instr_pc, instr_valid
    );

    modport slave (
        output jump, jump_addr, imem_ack, imem_rdata, instr_taken,
        input  imem_req, imem_addr, instr, instr_pc, instr_valid
    );

endinterface

// File: rtl/pc16.sv
// pc16: program counter register.
//   clk, reset    - clock and synchronous active-high reset (loads RESET_PC)
//   load/load_val - load a redirect target
//   inc           - advance by one, wrapping modulo 2^WIDTH
//   pc            - current value
// Priority: reset > load > inc.
module pc16
    import fetch16_pkg::*;
#(
    parameter int unsigned       WIDTH    = data_width,
    parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(reset_pc_default)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= load_val;
        end else if (inc) begin
            pc_q <= pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch16.sv
// fetch16: instruction-fetch stage of the Hack-style CPU.
//   clk, reset - clock and synchronous active-high reset
//   bus        - fetch16_if.master: jump redirect in, imem req/ack out/in,
//                held instr/instr_pc/instr_valid out with instr_taken in
// FETCH issues a request at pc until acked; HOLD presents the fetched word
// until it is taken or a jump redirects. A jump seen while a request is
// outstanding is parked in jump_pend/jump_tgt so imem_addr stays stable.
module fetch16
    import fetch16_pkg::*;
#(
    parameter int unsigned       WIDTH    = data_width,
    parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(reset_pc_default)
) (
    input logic      clk,
    input logic      reset,
    fetch16_if.master bus
);

    state_t           state_q, state_d;
    logic             jump_pend_q, jump_pend_d;
    logic [WIDTH-1:0] jump_tgt_q, jump_tgt_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] instr_pc_q, instr_pc_d;

    logic             pc_load;
    logic             pc_inc;
    logic [WIDTH-1:0] pc_load_val;
    logic [WIDTH-1:0] pc;

    pc16 #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= st_fetch;
            jump_pend_q <= 1'b0;
            jump_tgt_q  <= '0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            jump_pend_q <= jump_pend_d;
            jump_tgt_q  <= jump_tgt_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        jump_pend_d = jump_pend_q;
        jump_tgt_d  = jump_tgt_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load_val = bus.jump_addr;

        unique case (state_q)
            st_fetch: begin
                if (bus.imem_ack) begin
                    if (bus.jump || jump_pend_q) begin
                        // Redirect: the acked word belongs to the wrong path.
                        pc_load     = 1'b1;
                        pc_load_val = bus.jump ? bus.jump_addr : jump_tgt_q;
                        jump_pend_d = 1'b0;
                    end else begin
                        instr_d    = bus.imem_rdata;
                        instr_pc_d = pc;
                        pc_inc     = 1'b1;
                        state_d    = st_hold;
                    end
                end else if (bus.jump) begin
                    // Request in flight: keep imem_addr, remember the newest target.
                    jump_pend_d = 1'b1;
                    jump_tgt_d  = bus.jump_addr;
                end
            end
            st_hold: begin
                if (bus.jump) begin
                    pc_load = 1'b1;
                    state_d = st_fetch;
                end else if (bus.instr_taken) begin
                    state_d = st_fetch;
                end
            end
        endcase
    end

    // Outputs come from registers and state only.
    assign bus.imem_req    = (state_q == st_fetch);
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = (state_q == st_hold);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch16.sv
// tb_fetch16: self-checking bench for fetch16 with a transaction-level model.
module tb_fetch16;

    logic clk;
    logic reset;

    fetch16_if #(.WIDTH(16)) bus ();
    fetch16_if #(.WIDTH(16)) bus2 ();

    fetch16 #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Second instance for the PC wrap-around boundary.
    fetch16 #(.WIDTH(16), .RESET_PC(16'hFFFE)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Memory behaviour: acks after lat cycles, returns addr ^ key.
    int          lat  = 0;
    int          wcnt = 0;
    logic [15:0] key  = 16'hA5A5;

    // Reference model of the fetch stage as seen from outside.
    logic        m_hold  = 1'b0;
    logic [15:0] m_pc    = 16'h0000;
    logic        m_pend  = 1'b0;
    logic [15:0] m_tgt   = 16'h0000;
    logic [15:0] m_instr = 16'h0000;
    logic [15:0] m_ipc   = 16'h0000;

    // One clock cycle: check current outputs against the model, drive this
    // cycle's inputs, advance the model, then move to #1 after the next edge.
    task automatic step(input logic rst, input logic j, input logic [15:0] ja,
                        input logic tk);
        logic ack;
        n_cmp += 5;
        if (bus.imem_req !== !m_hold) begin
            n_bad++;
            $display("FAIL req: got %b want %b t=%0t", bus.imem_req, !m_hold, $time);
        end
        if (!m_hold && bus.imem_addr !== m_pc) begin
            n_bad++;
            $display("FAIL addr: got %h want %h t=%0t", bus.imem_addr, m_pc, $time);
        end
        if (bus.instr_valid !== m_hold) begin
            n_bad++;
            $display("FAIL valid: got %b want %b t=%0t", bus.instr_valid, m_hold, $time);
        end
        if (bus.instr !== m_instr) begin
            n_bad++;
            $display("FAIL instr: got %h want %h t=%0t", bus.instr, m_instr, $time);
        end
        if (bus.instr_pc !== m_ipc) begin
            n_bad++;
            $display("FAIL instr_pc: got %h want %h t=%0t", bus.instr_pc, m_ipc, $time);
        end

        ack = !rst && (bus.imem_req === 1'b1) && (wcnt >= lat);
        reset            = rst;
        bus.jump         = j;
        bus.jump_addr    = ja;
        bus.instr_taken  = tk;
        bus.imem_ack     = ack;
        bus.imem_rdata   = bus.imem_addr ^ key;
        bus2.jump        = 1'b0;
        bus2.jump_addr   = 16'h0000;
        bus2.instr_taken = 1'b1;
        bus2.imem_ack    = 1'b1;
        bus2.imem_rdata  = bus2.imem_addr ^ 16'hA5A5;

        if (rst) begin
            m_hold = 1'b0; m_pc = 16'h0000; m_pend = 1'b0; m_tgt = 16'h0000;
            m_instr = 16'h0000; m_ipc = 16'h0000; wcnt = 0;
        end else begin
            if (bus.imem_req === 1'b1 && !ack) wcnt++;
            else wcnt = 0;
            if (!m_hold) begin
                if (ack) begin
                    if (j) m_pc = ja;
                    else if (m_pend) m_pc = m_tgt;
                    else begin
                        m_instr = m_pc ^ key;
                        m_ipc   = m_pc;
                        m_pc    = m_pc + 16'd1;
                        m_hold  = 1'b1;
                    end
                    m_pend = 1'b0;
                end else if (j) begin
                    m_pend = 1'b1;
                    m_tgt  = ja;
                end
            end else if (j) begin
                m_pc   = ja;
                m_hold = 1'b0;
            end else if (tk) begin
                m_hold = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.jump = 1'b0; bus.jump_addr = 16'h0; bus.instr_taken = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0;
        bus2.jump = 1'b0; bus2.jump_addr = 16'h0; bus2.instr_taken = 1'b1;
        bus2.imem_ack = 1'b0; bus2.imem_rdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 6;
        if (bus.imem_req !== 1'b1) begin
            n_bad++; $display("FAIL reset_req: got %b want 1", bus.imem_req);
        end
        if (bus.imem_addr !== 16'h0000) begin
            n_bad++; $display("FAIL reset_addr: got %h want 0000", bus.imem_addr);
        end
        if (bus.instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid);
        end
        if (bus.instr !== 16'h0000) begin
            n_bad++; $display("FAIL reset_instr: got %h want 0000", bus.instr);
        end
        if (bus.instr_pc !== 16'h0000) begin
            n_bad++; $display("FAIL reset_ipc: got %h want 0000", bus.instr_pc);
        end
        if (bus2.imem_addr !== 16'hFFFE) begin
            n_bad++; $display("FAIL reset_pc_param: got %h want fffe", bus2.imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        logic [15:0] exp_i [3] = '{16'hA5A5, 16'hA5A4, 16'hA5A7};
        logic [15:0] exp_p [3] = '{16'h0000, 16'h0001, 16'h0002};
        logic [15:0] got_i [3];
        logic [15:0] got_p [3];
        int n = 0;
        lat = 0; key = 16'hA5A5;
        step(1'b1, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (bus.instr_valid !== ((i % 2) == 1)) begin
                n_bad++;
                $display("FAIL zw_valid_pattern: cycle %0d got %b want %b", i,
                         bus.instr_valid, (i % 2) == 1);
            end
            if (bus.instr_valid === 1'b1 && n < 3) begin
                got_i[n] = bus.instr; got_p[n] = bus.instr_pc; n++;
            end
            step(1'b0, 1'b0, 16'h0, 1'b1);
        end
        n_cmp++;
        if (n != 3) begin
            n_bad++; $display("FAIL zw_count: got %0d want 3", n);
        end
        for (int k = 0; k < n; k++) begin
            n_cmp++;
            if (got_i[k] !== exp_i[k] || got_p[k] !== exp_p[k]) begin
                n_bad++;
                $display("FAIL zw_seq[%0d]: got (%h,%h) want (%h,%h)", k, got_i[k],
                         got_p[k], exp_i[k], exp_p[k]);
            end
        end
    endtask

    task automatic test_latency_hold();
        bit got = 0;
        lat = 3; key = 16'hA5A5;
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 10 && !got; i++) begin
            if (bus.instr_valid === 1'b1) got = 1;
            else step(1'b0, 1'b0, 16'h0, 1'b0);
        end
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL lat_timeout: got no valid want valid within 10");
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bus.instr !== 16'hA5A5 || bus.imem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL lat_hold: got instr %h req %b want a5a5 0", bus.instr,
                         bus.imem_req);
            end
            step(1'b0, 1'b0, 16'h0, 1'b0);
        end
        step(1'b0, 1'b0, 16'h0, 1'b1);
        n_cmp++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0001) begin
            n_bad++;
            $display("FAIL lat_next: got req %b addr %h want 1 0001", bus.imem_req,
                     bus.imem_addr);
        end
    endtask

    task automatic test_jump_hold();
        bit got = 0;
        lat = 1; key = 16'h3C3C;
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b1, 16'h0100, 1'($urandom_range(0, 1)));
        n_cmp++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0100 ||
            bus.instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL jh_redirect: got req %b addr %h valid %b want 1 0100 0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        for (int i = 0; i < 6 && !got; i++) begin
            if (bus.instr_valid === 1'b1) got = 1;
            else step(1'b0, 1'b0, 16'h0, 1'b0);
        end
        n_cmp++;
        if (!got || bus.instr_pc !== 16'h0100 || bus.instr !== (16'h0100 ^ 16'h3C3C)) begin
            n_bad++;
            $display("FAIL jh_new_instr: got valid %b pc %h instr %h want 1 0100 %h",
                     got, bus.instr_pc, bus.instr, 16'h0100 ^ 16'h3C3C);
        end
    endtask

    task automatic test_jump_fetch();
        bit got = 0;
        lat = 4; key = 16'hA5A5;
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b1, 16'h0200, 1'b0);
        step(1'b0, 1'b1, 16'h0300, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
                n_bad++;
                $display("FAIL jf_stable: got req %b addr %h want 1 0000", bus.imem_req,
                         bus.imem_addr);
            end
            step(1'b0, 1'b0, 16'h0, 1'b0);
        end
        n_cmp++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 ||
            bus.imem_addr !== 16'h0300) begin
            n_bad++;
            $display("FAIL jf_redirect: got valid %b req %b addr %h want 0 1 0300",
                     bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
        for (int i = 0; i < 10 && !got; i++) begin
            if (bus.instr_valid === 1'b1) got = 1;
            else step(1'b0, 1'b0, 16'h0, 1'b0);
        end
        n_cmp++;
        if (!got || bus.instr_pc !== 16'h0300) begin
            n_bad++;
            $display("FAIL jf_target: got valid %b pc %h want 1 0300", got, bus.instr_pc);
        end
    endtask

    task automatic test_reset_mid();
        lat = 3; key = 16'hA5A5;
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b1, 16'h0555, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 ||
            bus.imem_addr !== 16'h0000) begin
            n_bad++;
            $display("FAIL rst_fetch: got valid %b req %b addr %h want 0 1 0000",
                     bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
        lat = 0;
        step(1'b0, 1'b0, 16'h0, 1'b0);
        // A surviving pending jump would discard this ack instead of holding it.
        n_cmp++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0000) begin
            n_bad++;
            $display("FAIL rst_pend_clear: got valid %b pc %h want 1 0000",
                     bus.instr_valid, bus.instr_pc);
        end
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 16'h0000 ||
            bus.instr !== 16'h0000) begin
            n_bad++;
            $display("FAIL rst_hold: got valid %b addr %h instr %h want 0 0000 0000",
                     bus.instr_valid, bus.imem_addr, bus.instr);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_p [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        logic [15:0] got_p [3];
        logic [15:0] got_i [3];
        int n = 0;
        lat = 0;
        step(1'b1, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (bus2.instr_valid === 1'b1 && n < 3) begin
                got_p[n] = bus2.instr_pc; got_i[n] = bus2.instr; n++;
            end
            step(1'b0, 1'b0, 16'h0, 1'b1);
        end
        n_cmp++;
        if (n != 3) begin
            n_bad++; $display("FAIL wrap_count: got %0d want 3", n);
        end
        for (int k = 0; k < n; k++) begin
            n_cmp++;
            if (got_p[k] !== exp_p[k] || got_i[k] !== (exp_p[k] ^ 16'hA5A5)) begin
                n_bad++;
                $display("FAIL wrap[%0d]: got (%h,%h) want (%h,%h)", k, got_p[k],
                         got_i[k], exp_p[k], exp_p[k] ^ 16'hA5A5);
            end
        end
    endtask

    task automatic test_random();
        key = 16'($urandom);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 500; i++) begin
            if (i % 25 == 0) lat = $urandom_range(0, 3);
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 5) == 0),
                 16'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency_hold();
        test_jump_hold();
        test_jump_fetch();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch16.md
# fetch16

Instruction-fetch stage for the 16-bit Hack-style CPU: it owns the program counter, fetches words from instruction memory over a req/ack handshake, and presents each fetched instruction with valid/taken flow control. Its `instr` output feeds the `a` input of the A-register `Mux16`, which selects between the instruction and the ALU result. It also accepts jump redirects from the execute stage.

## Interface
- `WIDTH`, default 16: data and address width.
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous reset, active-high.
- `jump` in 1: redirect request; sampled on every edge.
- `jump_addr` in WIDTH: redirect target; valid while `jump`=1.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out WIDTH: fetch address; stable while `imem_req`=1.
- `imem_ack` in 1: memory returns `imem_rdata`; meaningful only while `imem_req`=1.
- `imem_rdata` in WIDTH: fetched word.
- `instr` out WIDTH: held instruction, to the Mux16 `a` input.
- `instr_pc` out WIDTH: address of `instr`.
- `instr_valid` out 1: `instr` is valid.
- `instr_taken` in 1: consumer accepts `instr` this cycle.

## Operation
- FSM states: FETCH and HOLD, plus a 1-bit `jump_pend` register holding a target in `jump_tgt`.
- Reset: state=FETCH, pc=`RESET_PC`, `jump_pend`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0. `imem_req` is 1 in the first cycle after reset, with `imem_addr`=`RESET_PC`.
- FETCH: `imem_req`=1, `imem_addr`=pc, `instr_valid`=0.
  - On ack with no jump and no `jump_pend`: `instr`<=`imem_rdata`, `instr_pc`<=pc, pc<=pc+1, then go to HOLD.
  - On ack with `jump`=1 or `jump_pend`=1: discard the data and set pc<=target. Live `jump` has priority over `jump_pend`. Clear `jump_pend` and stay in FETCH.
  - On no ack with `jump`=1: `jump_pend`<=1 and `jump_tgt`<=`jump_addr`. pc and `imem_addr` do not change until the ack arrives.
- HOLD: `instr_valid`=1, `imem_req`=0.
  - `jump`=1 (with or without `instr_taken`): drop `instr`, set pc<=`jump_addr`, go to FETCH.
  - Otherwise, `instr_taken`=1 goes to FETCH with pc already incremented.
  - Otherwise, hold everything.
- Arithmetic: pc+1 is modulo 2^WIDTH, so 16'hFFFF wraps to 16'h0000 silently.
- `reset` overrides everything, including a pending ack or jump mid-transaction. A late ack is not expected after reset; the memory must drop its request on `imem_req` falling.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction every 2 cycles (FETCH, HOLD with immediate take).
- N-cycle memory latency: `instr_valid` rises one edge after the ack cycle.
- Jump in HOLD: `imem_req` with `imem_addr`=`jump_addr` appears the next cycle.
- Jump in FETCH: the redirected request appears the cycle after the outstanding ack.
- All outputs are registered or decoded from state only. There is no combinational path from `instr_taken` or `jump` to `imem_req` or `imem_addr`.
- A second `jump` while `jump_pend`=1 overwrites `jump_tgt` (last one wins).

## Structure
- Shared package or header: the FETCH/HOLD state encodings, the default `RESET_PC`, and the `WIDTH` define shared with `Mux16` and the CPU.
- One natural sub-module, `pc16`: a register with reset, load and increment, and a priority of reset > load > inc. The FSM drives its load and inc controls.

## Test plan
- Reset then zero-wait memory returning `addr ^ 16'hA5A5`, `instr_taken` tied 1 -> `instr`/`instr_pc` sequence (16'hA5A5,0), (16'hA5A4,1), (16'hA5A7,2), with `instr_valid` high every other cycle.
- Memory latency 3 with `instr_taken` held 0 for 5 cycles -> `instr` is stable, `imem_req`=0 throughout HOLD, and the next fetch is at `instr_pc`+1.
- In HOLD, `jump`=1 with `jump_addr`=16'h0100 -> the next cycle has `imem_req`=1 and `imem_addr`=16'h0100, and the old `instr` is never re-presented.
- Memory latency 4, `jump`=1 to 16'h0200 in the second wait cycle, then `jump`=1 to 16'h0300 in the third -> the outstanding address is held until ack, the ack data is discarded, and the next request is at 16'h0300.
- `RESET_PC`=16'hFFFE with sequential fetches -> `instr_pc` reads 16'hFFFE, 16'hFFFF, 16'h0000.
- `reset` asserted mid-FETCH and mid-HOLD -> the next cycle has `instr_valid`=0, `imem_addr`=`RESET_PC` and `jump_pend`=0.
